// File: rtl/pixel_fb_writer.sv
// Framebuffer write stage: clips rasterizer pixels, buffers them against RAM back-pressure,
// and sweeps a full-screen clear between frames.
module pixel_fb_writer #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned COLOR_W    = 12,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [15:0]        pix_x,
    input  logic [15:0]        pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_done,
    output logic               busy,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_stall,
    output logic [15:0]        clipped_cnt
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned EntW = ADDR_W + COLOR_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

    state_e              state_q, state_d;
    logic [EntW-1:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic                ready_en_q;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]  fb_data_q, fb_data_d;
    logic [COLOR_W-1:0]  clr_color_q;
    logic                clear_done_q, clear_done_d;
    logic [15:0]         clipped_q;

    logic                fifo_full, fifo_empty;
    logic                in_bounds, accept, push, pop, load;
    logic [ADDR_W-1:0]   pix_addr;

    assign fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_bounds  = (32'(pix_x) < SCREEN_W) && (32'(pix_y) < SCREEN_H);
    assign pix_addr   = ADDR_W'(32'(pix_y) * SCREEN_W + 32'(pix_x));

    // ready_en_q keeps pix_ready low throughout reset and releases it one clock later
    assign pix_ready  = ready_en_q && (state_q == StRun) && !fifo_full;
    assign accept     = pix_valid && pix_ready;
    assign push       = accept && in_bounds;
    assign load       = !fb_we_q || !fb_stall;

    always_comb begin
        state_d      = state_q;
        fb_we_d      = fb_we_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        clear_done_d = 1'b0;
        pop          = 1'b0;
        unique case (state_q)
            StRun, StDrain: begin
                if (load) begin
                    if (!fifo_empty) begin
                        pop                    = 1'b1;
                        fb_we_d                = 1'b1;
                        {fb_addr_d, fb_data_d} = mem_q[rd_ptr_q];
                    end else if (state_q == StDrain) begin
                        // Last pixel write taken: first clear write goes straight out
                        state_d   = StClear;
                        fb_we_d   = 1'b1;
                        fb_addr_d = '0;
                        fb_data_d = clr_color_q;
                    end else begin
                        fb_we_d = 1'b0;
                    end
                end
                if (state_q == StRun && clear_start) state_d = StDrain;
            end
            StClear: begin
                if (load) begin
                    if (fb_addr_q == LastAddr) begin
                        fb_we_d      = 1'b0;
                        clear_done_d = 1'b1;
                        state_d      = StRun;
                    end else begin
                        fb_addr_d = fb_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_en_q   <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            clr_color_q  <= '0;
            clear_done_q <= 1'b0;
            clipped_q    <= '0;
        end else begin
            state_q      <= state_d;
            ready_en_q   <= 1'b1;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            clear_done_q <= clear_done_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
            if (state_q == StRun && clear_start) clr_color_q <= clear_color;
            if (accept && !in_bounds && clipped_q != 16'hFFFF) clipped_q <= clipped_q + 1'b1;
        end
    end

    // Payload storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pix_addr, pix_color};
    end

    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_data     = fb_data_q;
    assign clear_done  = clear_done_q;
    assign clipped_cnt = clipped_q;
    assign busy        = !fifo_empty || fb_we_q || (state_q != StRun);

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: a full-size instance for pixel/clip/stall vectors and a
// small-screen instance (20x10) so clear sweeps stay short.
module tb_pixel_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid, clear_start, fb_stall;
    logic [15:0] pix_x, pix_y;
    logic [11:0] pix_color, clear_color;

    logic        pix_ready, clear_done, busy, fb_we;
    logic [18:0] fb_addr;
    logic [11:0] fb_data;
    logic [15:0] clipped_cnt;

    logic        pix_ready_s, clear_done_s, busy_s, fb_we_s;
    logic [7:0]  fb_addr_s;
    logic [11:0] fb_data_s;
    logic [15:0] clipped_cnt_s;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] wa_q[$], wd_q[$], sa_q[$], sd_q[$];

    always #5 clk = ~clk;

    pixel_fb_writer dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .clear_start(clear_start), .clear_color(clear_color), .clear_done(clear_done),
        .busy(busy), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_stall(fb_stall), .clipped_cnt(clipped_cnt)
    );

    pixel_fb_writer #(.SCREEN_W(20), .SCREEN_H(10), .ADDR_W(8)) dut_s (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready_s),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .clear_start(clear_start), .clear_color(clear_color), .clear_done(clear_done_s),
        .busy(busy_s), .fb_we(fb_we_s), .fb_addr(fb_addr_s), .fb_data(fb_data_s),
        .fb_stall(fb_stall), .clipped_cnt(clipped_cnt_s)
    );

    // Log every write the RAM actually takes
    always @(posedge clk) begin
        if (!rst) begin
            if (fb_we && !fb_stall) begin
                wa_q.push_back(32'(fb_addr));
                wd_q.push_back(32'(fb_data));
            end
            if (fb_we_s && !fb_stall) begin
                sa_q.push_back(32'(fb_addr_s));
                sd_q.push_back(32'(fb_data_s));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int x, input int y, input logic [11:0] c);
        pix_valid = 1'b1;
        pix_x     = 16'(x);
        pix_y     = 16'(y);
        pix_color = c;
    endtask

    task automatic pulse_clear(input logic [11:0] c);
        clear_color = c;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
    endtask

    initial begin
        int acc, bad, busy_bad, rdy_bad, done_cnt, cyc;
        logic rdy_now;
        logic [31:0] exp_a [4];
        exp_a[0] = 32'd21; exp_a[1] = 32'd62; exp_a[2] = 32'd199; exp_a[3] = 32'd0;

        rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
        clear_start = 1'b0; clear_color = '0; fb_stall = 1'b0;
        repeat (3) tick();
        check("rst_ready", 32'(pix_ready), 32'd0);
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_data", 32'(fb_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clip", 32'(clipped_cnt), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(pix_ready), 32'd1);

        // Basic addressing and latency
        drive_pix(3, 2, 12'hABC);
        tick();
        check("lat_we_early", 32'(fb_we), 32'd0);
        drive_pix(0, 0, 12'hABC);
        tick();
        check("px0_we", 32'(fb_we), 32'd1);
        check("px0_addr", 32'(fb_addr), 32'd1283);
        check("px0_data", 32'(fb_data), 32'hABC);
        drive_pix(639, 479, 12'hABC);
        tick();
        check("px1_we", 32'(fb_we), 32'd1);
        check("px1_addr", 32'(fb_addr), 32'd0);
        pix_valid = 1'b0;
        tick();
        check("px2_we", 32'(fb_we), 32'd1);
        check("px2_addr", 32'(fb_addr), 32'd307199);
        tick();
        check("px_idle_we", 32'(fb_we), 32'd0);
        check("px_idle_busy", 32'(busy), 32'd0);

        // Clipping and saturation
        drive_pix(640, 0, 12'h111);
        check("clip0_ready", 32'(pix_ready), 32'd1);
        tick();
        check("clip0_we", 32'(fb_we), 32'd0);
        drive_pix(0, 480, 12'h111);
        check("clip1_ready", 32'(pix_ready), 32'd1);
        tick();
        check("clip1_we", 32'(fb_we), 32'd0);
        drive_pix(65535, 5, 12'h111);
        check("clip2_ready", 32'(pix_ready), 32'd1);
        tick();
        pix_valid = 1'b0;
        tick();
        check("clip2_we", 32'(fb_we), 32'd0);
        check("clip_cnt3", 32'(clipped_cnt), 32'd3);
        drive_pix(700, 0, 12'h111);
        repeat (65537) tick();
        pix_valid = 1'b0;
        tick();
        check("clip_sat", 32'(clipped_cnt), 32'hFFFF);

        // Back-pressure: output frozen, FIFO fills
        wa_q.delete(); wd_q.delete();
        fb_stall = 1'b1;
        acc = 0; bad = 0;
        for (int c = 0; c < 10; c++) begin
            drive_pix(10 + acc, 1, 12'(acc + 1));
            rdy_now = pix_ready;
            tick();
            if (rdy_now) acc++;
            if (c >= 1 && (fb_we !== 1'b1 || fb_addr !== 19'd650)) bad++;
        end
        check("stall_accepts", 32'(acc), 32'd9);
        check("stall_ready", 32'(pix_ready), 32'd0);
        check("stall_frozen", 32'(bad), 32'd0);
        check("stall_no_take", 32'(wa_q.size()), 32'd0);
        pix_valid = 1'b0;
        fb_stall  = 1'b0;
        repeat (12) tick();
        check("stall_count", 32'(wa_q.size()), 32'd9);
        bad = 0;
        for (int i = 0; i < 9 && i < wa_q.size(); i++)
            if (wa_q[i] !== 32'(650 + i) || wd_q[i] !== 32'(i + 1)) bad++;
        check("stall_order", 32'(bad), 32'd0);

        // Clear with queued pixels (small instance)
        rst = 1'b1; tick(); rst = 1'b0; tick();
        sa_q.delete(); sd_q.delete();
        fb_stall = 1'b1;
        drive_pix(1, 1, 12'h5A5);  tick();
        drive_pix(2, 3, 12'h5A5);  tick();
        drive_pix(19, 9, 12'h5A5); tick();
        drive_pix(0, 0, 12'h5A5);  tick();
        pix_valid = 1'b0;
        pulse_clear(12'h000);
        check("clr_ready0", 32'(pix_ready_s), 32'd0);
        fb_stall = 1'b0;
        drive_pix(5, 5, 12'hFFF);
        rdy_bad = 0; busy_bad = 0; done_cnt = 0; cyc = 0;
        while (cyc < 1000 && !clear_done_s) begin
            if (pix_ready_s !== 1'b0) rdy_bad++;
            if (busy_s !== 1'b1) busy_bad++;
            tick();
            cyc++;
        end
        pix_valid = 1'b0;
        check("clr_timeout", 32'(clear_done_s), 32'd1);
        check("clr_done_we", 32'(fb_we_s), 32'd0);
        check("clr_done_busy", 32'(busy_s), 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (clear_done_s) done_cnt++;
            tick();
        end
        check("clr_pulses", 32'(done_cnt), 32'd1);
        check("clr_ready_low", 32'(rdy_bad), 32'd0);
        check("clr_busy_high", 32'(busy_bad), 32'd0);
        check("clr_count", 32'(sa_q.size()), 32'd204);
        bad = 0;
        for (int i = 0; i < 204 && i < sa_q.size(); i++) begin
            if (i < 4) begin
                if (sa_q[i] !== exp_a[i] || sd_q[i] !== 32'h5A5) bad++;
            end else if (sa_q[i] !== 32'(i - 4) || sd_q[i] !== 32'h000) begin
                bad++;
            end
        end
        check("clr_sequence", 32'(bad), 32'd0);

        // Clear under random stall
        sa_q.delete(); sd_q.delete();
        pulse_clear(12'h123);
        cyc = 0;
        while (cyc < 2000 && !clear_done_s) begin
            fb_stall = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        fb_stall = 1'b0;
        check("rclr_timeout", 32'(clear_done_s), 32'd1);
        check("rclr_count", 32'(sa_q.size()), 32'd200);
        bad = 0;
        for (int i = 0; i < 200 && i < sa_q.size(); i++)
            if (sa_q[i] !== 32'(i) || sd_q[i] !== 32'h123) bad++;
        check("rclr_sequence", 32'(bad), 32'd0);

        // Reset in the middle of a clear
        tick();
        pulse_clear(12'h0F0);
        cyc = 0;
        while (cyc < 400 && !(fb_we_s && fb_addr_s == 8'd100)) begin
            tick();
            cyc++;
        end
        check("mid_reach", 32'(fb_addr_s), 32'd100);
        rst = 1'b1;
        #1;
        check("mid_we_s", 32'(fb_we_s), 32'd0);
        check("mid_we", 32'(fb_we), 32'd0);
        check("mid_busy", 32'(busy_s), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_ready", 32'(pix_ready_s), 32'd1);
        drive_pix(1, 0, 12'h777);
        tick();
        pix_valid = 1'b0;
        tick();
        check("mid_px_we", 32'(fb_we_s), 32'd1);
        check("mid_px_addr_s", 32'(fb_addr_s), 32'd1);
        check("mid_px_addr", 32'(fb_addr), 32'd1);
        check("mid_px_data", 32'(fb_data_s), 32'h777);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
